packet_serializer: RTL and testbench
====================================

PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 64: bits per packet, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends packet_in[PACKET_SIZE-1] first; 0 sends packet_in[0] first.
REQ-003 SHALL have parameter IDLE_BIT, default 0: current_bit value when no packet is active.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port packet_in, input, PACKET_SIZE: packet offered for transmission.
REQ-007 SHALL have port load_valid, input, 1: packet_in valid.
REQ-008 SHALL have port load_ready, output, 1: block can accept packet_in this cycle.
REQ-009 SHALL have port next, input, 1: one-cycle symbol strobe from the modulator requesting the next bit.
REQ-010 SHALL have port current_bit, output, 1: bit presented to the modulator.
REQ-011 SHALL have port bit_valid, output, 1: current_bit belongs to an active packet.
REQ-012 SHALL have port last_bit, output, 1: current_bit is the final bit of its packet.
REQ-013 SHALL have port packet_done, output, 1: one-cycle pulse when the final bit is consumed.
REQ-014 SHALL have port underrun, output, 1: one-cycle pulse when next arrives with no active packet.

Function
REQ-015 SHALL hold two packet registers: active (being sent) and holding (queued), plus a bit index of width $clog2(PACKET_SIZE).
REQ-016 SHALL implement states IDLE (no active packet) and SEND (active packet presented).
REQ-017 SHALL drive load_ready = holding register empty, registered; a load is accepted when load_valid && load_ready.
REQ-018 In IDLE, an accepted load SHALL go directly to the active register: at the next edge, SEND, index 0, bit_valid=1, current_bit = first bit.
REQ-019 In SEND, an accepted load SHALL fill the holding register; load_ready deasserts the following cycle.
REQ-020 In SEND, next with index < PACKET_SIZE-1 SHALL increment index and present the next bit at the following edge.
REQ-021 In SEND, next with index = PACKET_SIZE-1 SHALL pulse packet_done for one cycle at the following edge.
REQ-022 At that final next with holding full, SHALL move holding to active, index 0, stay in SEND with no gap bit; load_ready reasserts the following cycle.
REQ-023 At that final next with holding empty, SHALL go to IDLE: bit_valid=0, current_bit=IDLE_BIT.
REQ-024 A load accepted in the same cycle as a final next with holding empty SHALL behave as in REQ-022 (back-to-back, no gap).
REQ-025 last_bit SHALL equal bit_valid && index = PACKET_SIZE-1.
REQ-026 next in IDLE SHALL pulse underrun next cycle and change no other state; a simultaneous load is still accepted.
REQ-027 next asserted on consecutive cycles SHALL advance one bit per cycle.
REQ-028 current_bit, bit_valid, last_bit, packet_done, underrun SHALL be registered outputs.

Reset
REQ-029 rst SHALL immediately force IDLE, index 0, both registers empty, current_bit=IDLE_BIT, bit_valid=0, last_bit=0, packet_done=0, underrun=0, load_ready=0.
REQ-030 load_ready SHALL assert on the first clock edge after rst deasserts.
REQ-031 rst mid-packet SHALL discard active and queued packets with no packet_done.

Structure
REQ-032 State encodings (IDLE, SEND) and default PACKET_SIZE SHALL live in shared package bpsk_pkg.
REQ-033 SHALL be a single module with no sub-modules; bit selection by index mux, not shifting.

Verification
REQ-034 PACKET_SIZE=8, MSB_FIRST=1, load 8'hA5, 8 next strobes -> bits 1,0,1,0,0,1,0,1; last_bit with 8th bit; packet_done once; then bit_valid=0, current_bit=0.
REQ-035 MSB_FIRST=0, load 8'h01 -> first current_bit=1 one cycle after acceptance, remaining seven 0.
REQ-036 Load 8'hFF then 8'h00 during sending -> load_ready low until swap; 16 contiguous bits with no gap; packet_done twice.
REQ-037 next while IDLE simultaneous with load of 8'h80 -> underrun one pulse; packet accepted; first bit 1.
REQ-038 rst asserted after 3 bits with holding full -> outputs reset without clock; no packet_done; load_ready=1 one edge after release.
REQ-039 next held high continuously on 8'h3C -> one bit per cycle, packet_done at cycle 8, IDLE after.

Source files
------------

// File: rtl/bpsk_pkg.sv
// bpsk_pkg
// Shared definitions for the BPSK transmit path.
//   state_t             : serializer state encoding (IDLE / SEND)
//   DEFAULT_PACKET_SIZE : default packet length in bits
package bpsk_pkg;

  localparam int DEFAULT_PACKET_SIZE = 64;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : bpsk_pkg

// File: rtl/packet_serializer.sv
// packet_serializer
// Turns parallel packets into a bit stream that a modulator pulls one bit at
// a time. The block holds one active packet and can queue one more. This lets
// packets run back-to-back with no gap bit.
//
// Parameters
//   PACKET_SIZE : bits per packet (>= 2)
//   MSB_FIRST   : 1 = packet_in[PACKET_SIZE-1] goes out first, 0 = packet_in[0] first
//   IDLE_BIT    : level of current_bit when no packet is active
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   packet_in   : packet offered for transmission
//   load_valid  : packet_in is valid
//   load_ready  : the block can take packet_in this cycle (holding slot empty)
//   next        : one-cycle strobe asking for the next bit
//   current_bit : bit presented to the modulator
//   bit_valid   : current_bit belongs to an active packet
//   last_bit    : current_bit is the final bit of its packet
//   packet_done : pulse after the final bit was consumed
//   underrun    : pulse after next arrived with no active packet
module packet_serializer
  import bpsk_pkg::*;
#(
  parameter int   PACKET_SIZE = DEFAULT_PACKET_SIZE,
  parameter int   MSB_FIRST   = 1,
  parameter logic IDLE_BIT    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] packet_in,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic                   next,
  output logic                   current_bit,
  output logic                   bit_valid,
  output logic                   last_bit,
  output logic                   packet_done,
  output logic                   underrun
);

  localparam int                 IDX_W    = $clog2(PACKET_SIZE);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PACKET_SIZE - 1);

  // Selects the transmitted bit by index. Packet registers stay static
  // while the bit is selected, so a swap from holding to active is one copy.
  function automatic logic pick_bit(input logic [PACKET_SIZE-1:0] pkt,
                                    input logic [IDX_W-1:0]       idx);
    logic [IDX_W-1:0] pos;
    if (MSB_FIRST != 0) begin
      pos = LAST_IDX - idx;
    end else begin
      pos = idx;
    end
    return pkt[pos];
  endfunction

  state_t                 state_r,     state_s;
  logic [PACKET_SIZE-1:0] active_r,    active_s;
  logic [PACKET_SIZE-1:0] holding_r,   holding_s;
  logic                   hold_full_r, hold_full_s;
  logic [IDX_W-1:0]       index_r,     index_s;

  logic current_bit_r, current_bit_s;
  logic bit_valid_r,   bit_valid_s;
  logic last_bit_r,    last_bit_s;
  logic done_r,        done_s;
  logic underrun_r,    underrun_s;
  logic load_ready_r,  load_ready_s;

  logic load_acc_s;

  // State, packet storage and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      active_r      <= '0;
      holding_r     <= '0;
      hold_full_r   <= 1'b0;
      index_r       <= '0;
      current_bit_r <= IDLE_BIT;
      bit_valid_r   <= 1'b0;
      last_bit_r    <= 1'b0;
      done_r        <= 1'b0;
      underrun_r    <= 1'b0;
      load_ready_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      active_r      <= active_s;
      holding_r     <= holding_s;
      hold_full_r   <= hold_full_s;
      index_r       <= index_s;
      current_bit_r <= current_bit_s;
      bit_valid_r   <= bit_valid_s;
      last_bit_r    <= last_bit_s;
      done_r        <= done_s;
      underrun_r    <= underrun_s;
      load_ready_r  <= load_ready_s;
    end
  end

  // Next-state logic. Outputs are computed from the next state and loaded into the output registers.
  always_comb begin
    state_s     = state_r;
    active_s    = active_r;
    holding_s   = holding_r;
    hold_full_s = hold_full_r;
    index_s     = index_r;
    done_s      = 1'b0;
    underrun_s  = 1'b0;
    load_acc_s  = load_valid && load_ready_r;

    case (state_r)
      ST_IDLE: begin
        // An underrun pulse does not block a simultaneous load.
        if (next) begin
          underrun_s = 1'b1;
        end else begin
          underrun_s = 1'b0;
        end
        if (load_acc_s) begin
          active_s = packet_in;
          index_s  = '0;
          state_s  = ST_SEND;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (next && (index_r == LAST_IDX)) begin
          done_s  = 1'b1;
          index_s = '0;
          if (hold_full_r) begin
            // load_ready is low while the slot is full, so no load competes here.
            active_s    = holding_r;
            hold_full_s = 1'b0;
          end else if (load_acc_s) begin
            // A packet arriving on the final strobe goes straight to active.
            active_s = packet_in;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          if (next) begin
            index_s = index_r + IDX_W'(1);
          end else begin
            index_s = index_r;
          end
          if (load_acc_s) begin
            holding_s   = packet_in;
            hold_full_s = 1'b1;
          end else begin
            hold_full_s = hold_full_r;
          end
        end
      end

      default: begin
        state_s     = ST_IDLE;
        index_s     = '0;
        hold_full_s = 1'b0;
      end
    endcase

    bit_valid_s  = (state_s == ST_SEND);
    load_ready_s = !hold_full_s;
    if (bit_valid_s) begin
      current_bit_s = pick_bit(active_s, index_s);
      last_bit_s    = (index_s == LAST_IDX);
    end else begin
      current_bit_s = IDLE_BIT;
      last_bit_s    = 1'b0;
    end
  end

  assign current_bit = current_bit_r;
  assign bit_valid   = bit_valid_r;
  assign last_bit    = last_bit_r;
  assign packet_done = done_r;
  assign underrun    = underrun_r;
  assign load_ready  = load_ready_r;

endmodule : packet_serializer

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer. It uses two 8-bit instances: one sends MSB first and one sends LSB first.
module tb_packet_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] packet_in  = 8'h00;
  logic       load_valid = 1'b0;
  logic       next       = 1'b0;
  logic       load_ready, current_bit, bit_valid, last_bit, packet_done, underrun;

  logic [7:0] l_packet_in  = 8'h00;
  logic       l_load_valid = 1'b0;
  logic       l_next       = 1'b0;
  logic       l_load_ready, l_current_bit, l_bit_valid, l_last_bit, l_packet_done, l_underrun;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic [7:0] pat;

  always #5 clk = ~clk;

  packet_serializer #(.PACKET_SIZE(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .packet_in(packet_in), .load_valid(load_valid),
    .load_ready(load_ready), .next(next), .current_bit(current_bit),
    .bit_valid(bit_valid), .last_bit(last_bit), .packet_done(packet_done),
    .underrun(underrun)
  );

  packet_serializer #(.PACKET_SIZE(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .packet_in(l_packet_in), .load_valid(l_load_valid),
    .load_ready(l_load_ready), .next(l_next), .current_bit(l_current_bit),
    .bit_valid(l_bit_valid), .last_bit(l_last_bit), .packet_done(l_packet_done),
    .underrun(l_underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " bit_valid"},   bit_valid,   1'b0);
    check({tag, " current_bit"}, current_bit, 1'b0);
    check({tag, " last_bit"},    last_bit,    1'b0);
  endtask

  initial begin
    // Reset is applied asynchronously before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst bit_valid",   bit_valid,   1'b0);
    check("rst current_bit", current_bit, 1'b0);
    check("rst last_bit",    last_bit,    1'b0);
    check("rst packet_done", packet_done, 1'b0);
    check("rst underrun",    underrun,    1'b0);
    check("rst load_ready",  load_ready,  1'b0);
    tick();
    check("rst held load_ready", load_ready, 1'b0);
    rst = 1'b0;
    check("pre-release edge load_ready", load_ready, 1'b0);
    tick();
    check("post-release load_ready", load_ready, 1'b1);
    check_idle("post-release");

    // MSB-first A5 with one idle cycle between strobes.
    pat = 8'hA5;
    packet_in = pat; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("A5 load_ready", load_ready, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      check("A5 bit_valid",   bit_valid,   1'b1);
      check("A5 current_bit", current_bit, pat[7-i]);
      check("A5 last_bit",    last_bit,    (i == 7));
      if (i == 3) begin
        tick();
        check("A5 hold current_bit", current_bit, pat[7-i]);
      end
      next = 1'b1;
      tick();
      next = 1'b0;
      if (packet_done) done_cnt++;
      check("A5 packet_done", packet_done, (i == 7));
    end
    check_idle("A5 end");
    tick();
    check("A5 done pulse width", packet_done, 1'b0);
    check("A5 done count", done_cnt, 1);

    // FF then 00 queued: 16 contiguous bits and a swap with no gap.
    packet_in = 8'hFF; load_valid = 1'b1;
    tick();
    packet_in = 8'h00;
    check("FF00 ready before queue", load_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    check("FF00 ready queued", load_ready, 1'b0);
    done_cnt = 0;
    next = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("FF00 bit_valid",   bit_valid,   1'b1);
      check("FF00 current_bit", current_bit, (i < 8));
      check("FF00 last_bit",    last_bit,    (i == 7) || (i == 15));
      check("FF00 load_ready",  load_ready,  (i >= 8));
      tick();
      if (packet_done) done_cnt++;
      check("FF00 packet_done", packet_done, (i == 7) || (i == 15));
    end
    next = 1'b0;
    check_idle("FF00 end");
    check("FF00 done count", done_cnt, 2);

    // next while idle with a simultaneous load of 80.
    pat = 8'h80;
    packet_in = pat; load_valid = 1'b1; next = 1'b1;
    tick();
    load_valid = 1'b0; next = 1'b0;
    check("80 underrun",    underrun,    1'b1);
    check("80 bit_valid",   bit_valid,   1'b1);
    check("80 current_bit", current_bit, 1'b1);
    tick();
    check("80 underrun pulse", underrun,    1'b0);
    check("80 hold bit",       current_bit, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check("80 current_bit", current_bit, pat[7-i]);
      next = 1'b1;
      tick();
      next = 1'b0;
    end
    check("80 last_bit", last_bit, 1'b1);
    // A load on the final strobe with an empty holding slot goes straight to active.
    packet_in = 8'h55; load_valid = 1'b1; next = 1'b1;
    tick();
    load_valid = 1'b0; next = 1'b0;
    check("55 packet_done", packet_done, 1'b1);
    check("55 bit_valid",   bit_valid,   1'b1);
    check("55 current_bit", current_bit, 1'b0);
    check("55 last_bit",    last_bit,    1'b0);
    check("55 load_ready",  load_ready,  1'b1);
    pat = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("55 current_bit", current_bit, pat[7-i]);
      next = 1'b1;
      tick();
      next = 1'b0;
    end
    packet_in = 8'h3C; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("55 queued ready", load_ready, 1'b0);
    check("55 bit4",         current_bit, pat[4]);

    // Asynchronous reset in mid-packet with the holding slot full.
    #2 rst = 1'b1;
    #1;
    check("mid rst bit_valid",   bit_valid,   1'b0);
    check("mid rst current_bit", current_bit, 1'b0);
    check("mid rst last_bit",    last_bit,    1'b0);
    check("mid rst packet_done", packet_done, 1'b0);
    check("mid rst underrun",    underrun,    1'b0);
    check("mid rst load_ready",  load_ready,  1'b0);
    next = 1'b1;
    tick();
    check("mid rst held done", packet_done, 1'b0);
    next = 1'b0;
    rst = 1'b0;
    tick();
    check("mid rst release ready", load_ready,  1'b1);
    check("mid rst release done",  packet_done, 1'b0);
    check_idle("mid rst release");

    // 3C with next held high continuously.
    pat = 8'h3C;
    packet_in = pat; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("3C current_bit", current_bit, pat[7-i]);
      check("3C last_bit",    last_bit,    (i == 7));
      tick();
      check("3C packet_done", packet_done, (i == 7));
    end
    check_idle("3C end");
    tick();
    check("3C underrun after", underrun,    1'b1);
    check("3C done cleared",   packet_done, 1'b0);
    next = 1'b0;
    tick();
    check("3C underrun pulse", underrun, 1'b0);

    // LSB-first instance: 01 sends a 1 first and then seven 0s.
    pat = 8'h01;
    l_packet_in = pat; l_load_valid = 1'b1;
    tick();
    l_load_valid = 1'b0;
    check("lsb first bit", l_current_bit, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("lsb bit_valid",   l_bit_valid,   1'b1);
      check("lsb current_bit", l_current_bit, pat[i]);
      check("lsb last_bit",    l_last_bit,    (i == 7));
      l_next = 1'b1;
      tick();
      l_next = 1'b0;
      check("lsb packet_done", l_packet_done, (i == 7));
    end
    check("lsb end bit_valid", l_bit_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_packet_serializer
